// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// on flush/stall/idle decode, and a saturating stall counter.
// Optional feature: define ID_EX_WB_BYPASS_EN to forward the writeback port
// into the captured operands when it targets a source register of the
// instruction in decode.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst,

  input  logic        id_valid,
  input  logic [31:0] id_read_data1,
  input  logic [31:0] id_read_data2,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [15:0] id_imm16,

  input  logic        id_regWrite,
  input  logic        id_memRead,
  input  logic        id_memWrite,
  input  logic        id_memToReg,
  input  logic        id_aluSrc,
  input  logic        id_regDst,
  input  logic [3:0]  id_aluOp,

  input  logic        flush,
  input  logic        wb_regWrite,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,

  output logic        ex_valid,
  output logic [31:0] ex_a,
  output logic [31:0] ex_b,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_wreg,
  output logic        ex_regWrite,
  output logic        ex_memRead,
  output logic        ex_memWrite,
  output logic        ex_memToReg,
  output logic        ex_aluSrc,
  output logic [3:0]  ex_aluOp,
  output logic        stall,
  output logic [15:0] stall_count
);

  logic        hazard;
  logic        load_bubble;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] imm_ext;
  logic [4:0]  wreg_sel;
  logic [15:0] stall_cnt_q;

  // Load-use hazard: a load in EX writes a register the decode instruction reads.
  // $0 is never a real dependency; a flush squashes decode so no stall is needed.
  always_comb begin
    hazard = 1'b0;
    if (ex_valid && ex_memRead && (ex_rt != 5'd0) && id_valid && !flush) begin
      hazard = (ex_rt == id_rs) || (ex_rt == id_rt);
    end
  end

  assign stall       = hazard;
  assign load_bubble = flush || hazard || !id_valid;

`ifdef ID_EX_WB_BYPASS_EN
  // Forward the writeback value over stale register-file data for matching sources.
  always_comb begin
    op_a = id_read_data1;
    op_b = id_read_data2;
    if (wb_regWrite && (wb_rd != 5'd0) && (wb_rd == id_rs)) begin
      op_a = wb_data;
    end
    if (wb_regWrite && (wb_rd != 5'd0) && (wb_rd == id_rt)) begin
      op_b = wb_data;
    end
  end
`else
  logic unused_wb;
  assign unused_wb = ^{wb_regWrite, wb_rd, wb_data};

  // Register-file data is captured as read.
  always_comb begin
    op_a = id_read_data1;
    op_b = id_read_data2;
  end
`endif

  // Immediate sign extension and destination register selection.
  always_comb begin
    imm_ext  = {{16{id_imm16[15]}}, id_imm16};
    wreg_sel = id_regDst ? id_rd : id_rt;
  end

  // Pipeline register: bubble on flush/stall/idle decode, otherwise capture decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_a        <= '0;
      ex_b        <= '0;
      ex_imm      <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_wreg     <= '0;
      ex_regWrite <= 1'b0;
      ex_memRead  <= 1'b0;
      ex_memWrite <= 1'b0;
      ex_memToReg <= 1'b0;
      ex_aluSrc   <= 1'b0;
      ex_aluOp    <= '0;
    end else if (load_bubble) begin
      ex_valid    <= 1'b0;
      ex_a        <= '0;
      ex_b        <= '0;
      ex_imm      <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_wreg     <= '0;
      ex_regWrite <= 1'b0;
      ex_memRead  <= 1'b0;
      ex_memWrite <= 1'b0;
      ex_memToReg <= 1'b0;
      ex_aluSrc   <= 1'b0;
      ex_aluOp    <= '0;
    end else begin
      ex_valid    <= 1'b1;
      ex_a        <= op_a;
      ex_b        <= op_b;
      ex_imm      <= imm_ext;
      ex_rs       <= id_rs;
      ex_rt       <= id_rt;
      ex_wreg     <= wreg_sel;
      ex_regWrite <= id_regWrite;
      ex_memRead  <= id_memRead;
      ex_memWrite <= id_memWrite;
      ex_memToReg <= id_memToReg;
      ex_aluSrc   <= id_aluSrc;
      ex_aluOp    <= id_aluOp;
    end
  end

  // Stall event counter, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (hazard && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_count = stall_cnt_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-high reset.
REQ-002 SHALL have ports: id_valid in 1 decode holds a live instruction; id_read_data1, id_read_data2 in 32 register-file read data; id_rs, id_rt, id_rd in 5 decoded register fields; id_imm16 in 16 raw immediate.
REQ-003 SHALL have ports: id_regWrite, id_memRead, id_memWrite, id_memToReg, id_aluSrc, id_regDst in 1 each; id_aluOp in 4 decode control.
REQ-004 SHALL have ports: flush in 1 branch-taken squash; wb_regWrite in 1, wb_rd in 5, wb_data in 32 writeback port as driven into the register file.
REQ-005 SHALL have ports: ex_valid out 1; ex_a, ex_b, ex_imm out 32; ex_rs, ex_rt, ex_wreg out 5; ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg, ex_aluSrc out 1; ex_aluOp out 4; stall out 1 hold PC and IF/ID; stall_count out 16.

Function
REQ-006 SHALL register all ex_* outputs on rising clk; latency decode-to-EX exactly 1 cycle.
REQ-007 SHALL compute ex_imm as id_imm16 sign-extended to 32 bits.
REQ-008 SHALL compute ex_wreg as id_rd when id_regDst=1, else id_rt.
REQ-009 SHALL assert stall combinationally when ex_valid=1, ex_memRead=1, ex_rt!=0, id_valid=1, (ex_rt==id_rs or ex_rt==id_rt), and flush=0.
REQ-010 SHALL, per edge, load in priority: flush=1 -> bubble; stall=1 -> bubble; id_valid=0 -> bubble; else capture decode inputs with ex_valid=1.
REQ-011 A bubble SHALL set ex_valid and all ex_* control bits (regWrite, memRead, memWrite, memToReg, aluSrc, aluOp) to 0; data/register fields SHALL be 0.
REQ-012 Load-use stall SHALL last exactly one cycle per dependent instruction (bubble clears ex_memRead, deasserting stall next cycle).
REQ-013 Flush and load-use in the same cycle: flush wins, stall SHALL be 0, bubble inserted.
REQ-014 stall_count SHALL increment by 1 on each edge where stall=1, saturating at 16'hFFFF (no wrap).
REQ-015 Register $0 dependencies (ex_rt=0) SHALL never cause stall.

Reset
REQ-016 rst=1 SHALL immediately and asynchronously force ex_valid=0, all ex_* outputs to 0, stall_count=0; stall therefore 0.
REQ-017 rst asserted mid-stall SHALL cancel the stall; first post-reset edge behaves per REQ-010.

Configuration
REQ-018 Macro ID_EX_WB_BYPASS_EN, when defined, SHALL substitute wb_data for id_read_data1 (resp. id_read_data2) before capture whenever wb_regWrite=1, wb_rd!=0 and wb_rd==id_rs (resp. id_rt).
REQ-019 Without ID_EX_WB_BYPASS_EN, id_read_data1/2 SHALL be captured unmodified and wb_* inputs SHALL be ignored.

Verification
REQ-020 Reset: rst=1 with all inputs non-zero -> all outputs 0 without clock edge; stall_count=0.
REQ-021 Pass-through: id_valid=1, rs=3, rt=4, rd=5, regDst=1, imm16=16'hFFFE, data1=32'h11 -> next edge ex_wreg=5, ex_imm=32'hFFFFFFFE, ex_a=32'h11, ex_valid=1.
REQ-022 Load-use: EX holds memRead=1, rt=7; ID rs=7 -> stall=1 one cycle, bubble (ex_valid=0), stall_count=1; next cycle instruction captured, stall=0.
REQ-023 Flush+hazard: same as REQ-022 with flush=1 -> stall=0, bubble, stall_count unchanged.
REQ-024 Bypass (macro on): wb_regWrite=1, wb_rd=9, wb_data=32'hCAFE, id_rs=9, data1=32'h0 -> ex_a=32'hCAFE; macro off -> ex_a=32'h0; wb_rd=0 -> no substitution.
REQ-025 Saturation: force 65,536 consecutive stall cycles -> stall_count holds 16'hFFFF.
